fadd_arbiter: RTL and testbench
===============================

# fadd_arbiter

Shares a single combinational IEEE-754 single-precision adder among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester at a time, drives the adder from registered operands and captures the sum. It returns the sum with the winner's ID on one response channel that supports backpressure. The block sits between the compute clients and the adder instance; the adder stays outside it and connects through the `add_*` ports.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: requester ID width; must equal clog2(`NUM_REQ`).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  requester i has an operand pair.
- `req_ready`  out  `NUM_REQ`  one-hot accept strobe, high for exactly one cycle.
- `req_a`  in  `NUM_REQ`*32  operand A; requester i in bits [32i+31:32i].
- `req_b`  in  `NUM_REQ`*32  operand B, same packing as `req_a`.
- `add_a`  out  32  adder operand A, registered.
- `add_b`  out  32  adder operand B, registered.
- `add_sum`  in  32  adder result, combinational from `add_a`/`add_b`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  `ID_W`  index of the requester that owns the response.
- `rsp_sum`  out  32  registered sum.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, select a winner, pulse `req_ready[winner]`, latch `req_a`/`req_b` into `add_a`/`add_b`, latch the winner into `rsp_id`, then go to EXEC.
  - Otherwise stay in IDLE.
- **EXEC**
  - `rsp_sum <= add_sum`, then go to RESP.
  - Fixed one-cycle stay; no request is accepted.
- **RESP**
  - `rsp_valid` = 1.
  - When `rsp_ready` = 1, go to IDLE.
  - With `rsp_ready` low, `rsp_sum`/`rsp_id` hold stable indefinitely and no request is accepted.
- **Arbitration (round-robin)**
  - Pointer `ptr` is reset to 0.
  - Search for the winner starts at `ptr` and wraps modulo `NUM_REQ`.
  - On accept, `ptr <= winner+1`, wrapping from `NUM_REQ`-1 to 0.
- **Handshake rules**
  - A requester keeps `req_valid` and its operands stable until it sees `req_ready`.
  - `req_ready` is never high for a requester whose `req_valid` is low.
  - A requester that deasserts `req_valid` before being granted loses nothing and is skipped.
- **Operand/result values:** operands and results pass through unmodified, including zero, inf, NaN and denormal encodings. Rounding and special cases belong to the adder.
- **`add_a`/`add_b`:** hold their last values outside EXEC.
- **Reset values:** `req_ready` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_sum` 0, `add_a` 0, `add_b` 0, `busy` 0, state IDLE, `ptr` 0.
- **Reset mid-operation:** the in-flight transaction is dropped and no response is issued. The requester's handshake is already complete, so the requester does not see this.

## Timing
- Accept edge (cycle T) → EXEC in T+1 → `rsp_valid` high from T+2.
- Accept-to-response latency: 2 cycles.
- Earliest next accept: the cycle after the `rsp_valid && rsp_ready` edge.
- Peak throughput: one operation per 3 cycles.
- `req_ready` is decoded combinationally from state, `ptr` and `req_valid` in IDLE. It is the only combinational output.
- Every other output is a flop output.
- `add_sum` must settle within one cycle of `add_a`/`add_b` changing. The adder path is registered on both sides.

## Configuration
- Macro: `FADD_ARB_RR_EN`.
- **Defined:** round-robin arbitration as described above.
- **Not defined:**
  - Fixed priority; the lowest index wins.
  - `ptr` is not implemented.
  - Starvation of high indices is accepted.
- Handshake, latency and reset behaviour are identical in both builds.

## Structure
- Package `fadd_arb_pkg` holds:
  - `FP_W` = 32.
  - The state enum `fadd_arb_state_t` (IDLE, EXEC, RESP).
  - The field-width constants for sign, exponent and mantissa (1/8/23), for benches.
- Sub-module `fadd_rr_pick`, combinational:
  - Inputs: `req_valid` vector and `ptr`.
  - Outputs: one-hot grant and encoded index.
  - When `FADD_ARB_RR_EN` is not defined, it degenerates to a priority encoder.
- The FSM, operand/result registers and pointer live in `fadd_arbiter`.

## Test plan
- **Single request:** requester 2 presents 1.0 + 2.0 (0x3F800000, 0x40000000) → `req_ready[2]` for one cycle; `rsp_valid` two cycles later with `rsp_sum` 0x40400000, `rsp_id` 2.
- **Mixed signs:** 3.0 + -1.0 (0x40400000, 0xBF800000) on requester 0 → `rsp_sum` 0x40000000, `rsp_id` 0.
- **Round-robin fairness:** all four `req_valid` held high with `rsp_ready`=1 → grant order 0,1,2,3,0,1; accepts spaced exactly 3 cycles apart.
- **Backpressure:** `rsp_ready` low for 5 cycles in RESP → `rsp_sum`/`rsp_id` stable, all `req_ready` 0, `busy` 1; release → IDLE the next cycle.
- **Reset in EXEC:** `rst` asserted for one cycle → every output at its reset value the next cycle, `rsp_valid` never asserts for the dropped operation, next grant starts from requester 0.
- **Fixed priority (`FADD_ARB_RR_EN` not defined):** requesters 0 and 3 continuously valid → requester 0 wins every grant.

Source files
------------

// File: rtl/fadd_arb_pkg.sv
// Shared definitions for the floating-point adder arbiter.
//   FP_W              : operand/result width (IEEE-754 single precision)
//   FP_SIGN_W/EXP_W/MAN_W : field widths of a single-precision word
//   fadd_arb_state_t  : arbiter FSM states (IDLE, EXEC, RESP)
package fadd_arb_pkg;

  localparam int FP_W      = 32;
  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } fadd_arb_state_t;

endpackage

// File: rtl/fadd_rr_pick.sv
// Combinational winner selection for the adder arbiter.
// Build option: FADD_ARB_RR_EN
//   defined     : round-robin search starting at ptr, wrapping mod NUM_REQ
//   not defined : fixed priority, lowest index wins (no ptr port)
// Ports:
//   req_valid [NUM_REQ] : requesters with a pending operand pair
//   ptr       [ID_W]    : first index to consider (round-robin build only)
//   grant     [NUM_REQ] : one-hot winner, all zero when nothing is valid
//   idx       [ID_W]    : encoded winner index, 0 when nothing is valid
module fadd_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
`ifdef FADD_ARB_RR_EN
  input  logic [ID_W-1:0]    ptr,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

`ifdef FADD_ARB_RR_EN
  logic found;

  // Walk the requesters in order ptr, ptr+1, ... and take the first valid one.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end
`else
  // Scan from the top down so the lowest valid index is the last (winning) write.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = ID_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one external combinational FP32 adder among NUM_REQ requesters.
// A winner is accepted in IDLE, its operands are registered onto add_a/add_b,
// the adder result is captured in EXEC, and the sum is offered with the
// winner's ID in RESP until the consumer takes it.
// Build option: FADD_ARB_RR_EN (round-robin when defined, fixed priority otherwise)
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot, combinational)
//   req_a/req_b         : packed operands, requester i in bits [32i+31:32i]
//   add_a/add_b/add_sum : registered operands to, and result from, the adder
//   rsp_valid/rsp_ready : response handshake with backpressure
//   rsp_id/rsp_sum      : owner index and registered sum
//   busy                : high whenever the FSM is not in IDLE
module fadd_arbiter
  import fadd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [FP_W-1:0]         add_a,
  output logic [FP_W-1:0]         add_b,
  input  logic [FP_W-1:0]         add_sum,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_sum,
  output logic                    busy
);

  fadd_arb_state_t state_reg, state_next;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_idx;
  logic               accept;

  logic [FP_W-1:0] add_a_reg, add_b_reg, rsp_sum_reg;
  logic [ID_W-1:0] rsp_id_reg;
  logic            rsp_valid_reg, busy_reg;

  logic [FP_W-1:0] a_arr [NUM_REQ];
  logic [FP_W-1:0] b_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*FP_W +: FP_W];
      assign b_arr[gi] = req_b[gi*FP_W +: FP_W];
    end
  endgenerate

`ifdef FADD_ARB_RR_EN
  logic [ID_W-1:0] ptr_reg;

  fadd_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_reg),
    .grant     (grant),
    .idx       (win_idx)
  );
`else
  fadd_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_valid (req_valid),
    .grant     (grant),
    .idx       (win_idx)
  );
`endif

  // Next state and the only combinational output, req_ready.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          req_ready  = grant;
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      add_a_reg     <= '0;
      add_b_reg     <= '0;
      rsp_sum_reg   <= '0;
      rsp_id_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef FADD_ARB_RR_EN
      ptr_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      // Flag outputs are registered from the next state so they line up with state_reg.
      busy_reg      <= (state_next != IDLE);
      rsp_valid_reg <= (state_next == RESP);
      if (accept) begin
        add_a_reg  <= a_arr[win_idx];
        add_b_reg  <= b_arr[win_idx];
        rsp_id_reg <= win_idx;
`ifdef FADD_ARB_RR_EN
        if (win_idx == ID_W'(NUM_REQ - 1)) ptr_reg <= '0;
        else                               ptr_reg <= win_idx + 1'b1;
`endif
      end
      // The adder has had a full cycle to settle on the operands latched at accept.
      if (state_reg == EXEC) rsp_sum_reg <= add_sum;
    end
  end

  assign add_a     = add_a_reg;
  assign add_b     = add_b_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_valid = rsp_valid_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Self-checking bench for fadd_arbiter (4 requesters).
// Follows FADD_ARB_RR_EN the same way the design does.
module tb_fadd_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  add_a, add_b, add_sum, rsp_sum;
  logic         rsp_valid, rsp_ready, busy;
  logic [1:0]   rsp_id;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ptr_m = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external adder: exact sums for the directed FP pairs,
  // otherwise an order-sensitive scramble so swapped or stale operands show up.
  function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
    return (a ^ 32'h9E3779B9) + {b[15:0], b[31:16]};
  endfunction

  assign add_sum = fadd_model(add_a, add_b);

  fadd_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference winner: which requester the arbitration rule picks right now.
  function automatic int model_pick(input logic [3:0] v);
`ifdef FADD_ARB_RR_EN
    for (int k = 0; k < 4; k++) if (v[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
`else
    for (int k = 0; k < 4; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]       = 1'b1;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] specials [6];
    specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000, 32'h00000001, 32'hFF800000};
    if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
    return $urandom;
  endfunction

  task automatic check_reset_vals();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id",    rsp_id,    0);
    chk("rst_rsp_sum",   rsp_sum,   0);
    chk("rst_add_a",     add_a,     0);
    chk("rst_add_b",     add_b,     0);
    chk("rst_busy",      busy,      0);
  endtask

  // One full transaction. Entered at a negedge with IDLE expected; returns at a
  // negedge back in IDLE. bp = cycles of rsp_ready low while in RESP.
  task automatic run_txn(input int bp, output int w);
    int waitc;
    logic [31:0] ea, eb, es;
    w = -1;
    #1;
    waitc = 0;
    while (req_ready == 4'b0 && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc == 10) begin
      tests++; fails++;
      $error("FAIL grant_timeout: observed no req_ready within 10 cycles, expected a grant");
      return;
    end
    w  = model_pick(req_valid);
    if (w < 0) return;
    ea = req_a[w*32 +: 32];
    eb = req_b[w*32 +: 32];
    es = fadd_model(ea, eb);
    chk("grant_onehot", req_ready, 32'(4'b1 << w));
    chk("idle_busy", busy, 0);
    rsp_ready = (bp == 0);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid[w] = 1'b0;
    ptr_m = (w + 1) % 4;
    @(negedge clk);
    chk("exec_ready", req_ready, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_busy", busy, 1);
    chk("exec_add_a", add_a, ea);
    chk("exec_add_b", add_b, eb);
    @(negedge clk);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_id", rsp_id, w);
    chk("resp_sum", rsp_sum, es);
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, w);
      chk("bp_sum", rsp_sum, es);
      chk("bp_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_busy", busy, 0);
    $display("[TB] txn id=%0d a=%h b=%h sum=%h bp=%0d", w, ea, eb, es, bp);
  endtask

  initial begin
    int w, prev;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals();

    // Single request on requester 2: 1.0 + 2.0
    set_req(2, 32'h3F800000, 32'h40000000);
    run_txn(0, w);
    chk("single_sum", rsp_sum, 32'h40400000);

    // Mixed signs on requester 0: 3.0 + -1.0
    set_req(0, 32'h40400000, 32'hBF800000);
    run_txn(0, w);
    chk("mixed_sum", rsp_sum, 32'h40000000);

    // All requesters held valid: grant order follows the rule, accepts 3 cycles apart
    for (int i = 0; i < 4; i++) set_req(i, rand_op(), rand_op());
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      run_txn(0, w);
      if (k > 0) chk("spacing", acc_cyc - prev, 3);
      prev = acc_cyc;
      if (w >= 0) set_req(w, rand_op(), rand_op());
    end
    req_valid = '0;

    // Backpressure for 5 cycles
    set_req(1, rand_op(), rand_op());
    run_txn(5, w);

    // Reset while in EXEC: transaction on requester 1 is dropped
    set_req(1, rand_op(), rand_op());
    #1;
    chk("rstx_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("rstx_exec_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals();
    ptr_m = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstx_no_rsp", rsp_valid, 0);
    end
    set_req(0, rand_op(), rand_op());
    set_req(2, rand_op(), rand_op());
    run_txn(0, w);
    chk("rstx_first_grant", w, 0);
    req_valid = '0;

    // Requesters 0 and 3 continuously valid
    set_req(0, rand_op(), rand_op());
    set_req(3, rand_op(), rand_op());
    for (int k = 0; k < 4; k++) begin
      run_txn(0, w);
`ifndef FADD_ARB_RR_EN
      chk("fixed_prio", w, 0);
`endif
      if (w >= 0) set_req(w, rand_op(), rand_op());
    end
    req_valid = '0;

    // Random traffic: pending requesters stay valid with stable operands
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && $urandom_range(1) == 1) set_req(i, rand_op(), rand_op());
      if (req_valid == 4'b0) set_req($urandom_range(3), rand_op(), rand_op());
      run_txn($urandom_range(3), w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
